// File: rtl/cnn_layer_accel_weight_table_pp.sv
// Ping-pong weight table: the host fills one bank while the CE DSP array reads the other.
// Define WHT_TABLE_PARITY_EN to store and check an even-parity bit per weight word.
module cnn_layer_accel_weight_table_pp #(
  parameter int unsigned C_WEIGHT_WIDTH   = 16,
  parameter int unsigned C_NUM_RD_PORTS   = 2,
  parameter int unsigned C_KERNEL_SIZE    = 9,
  parameter int unsigned C_SEQ_ADDR_WIDTH = 4,
  parameter int unsigned C_MAX_GROUPS     = 64,
  parameter int unsigned C_SEQ_ADDR_DELAY = 3,
  parameter int unsigned C_RD_LATENCY     = 3
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         job_accept,
  input  logic                                         kernel_config_valid,
  input  logic [$clog2(C_MAX_GROUPS)-1:0]              kernel_full_count,
  input  logic                                         wht_config_wren,
  input  logic [C_WEIGHT_WIDTH-1:0]                    wht_config_data,
  output logic                                         wht_config_ready,
  output logic                                         cfg_overflow,
  input  logic                                         ce_execute,
  input  logic [C_NUM_RD_PORTS*C_SEQ_ADDR_WIDTH-1:0]   wht_seq_addr,
  input  logic                                         next_kernel,
  output logic                                         last_kernel,
  output logic                                         bank_swap,
  output logic [C_NUM_RD_PORTS*C_WEIGHT_WIDTH-1:0]     wht_table_dout,
  output logic                                         wht_table_dout_valid,
  output logic                                         parity_err
);

  localparam int unsigned GW  = $clog2(C_MAX_GROUPS);
  localparam int unsigned SAW = C_SEQ_ADDR_WIDTH;
  localparam int unsigned AW  = 1 + GW + SAW;
  localparam int unsigned TOT = C_SEQ_ADDR_DELAY + C_RD_LATENCY;
`ifdef WHT_TABLE_PARITY_EN
  localparam int unsigned DW  = C_WEIGHT_WIDTH + 1;
`else
  localparam int unsigned DW  = C_WEIGHT_WIDTH;
`endif
  localparam logic [SAW-1:0] KMax = SAW'(C_KERNEL_SIZE - 1);

  typedef enum logic [1:0] {BkEmpty, BkLoading, BkLoaded, BkActive} bank_state_e;

  bank_state_e   bank_q [2], bank_d [2];
  logic [GW-1:0] full_q [2], full_d [2];
  logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [GW-1:0] wr_group_q, wr_group_d, rd_group_q, rd_group_d;
  logic [SAW-1:0] wr_count_q, wr_count_d;
  logic          ready_q, ready_d, overflow_q, overflow_d, swap_q, swap_d;

  logic [TOT-1:0]          vld_q, nk_q;
  logic [C_RD_LATENCY-1:0] lk_q;
  logic [C_SEQ_ADDR_DELAY-1:0][C_NUM_RD_PORTS-1:0][AW-1:0] addr_q;
  logic [C_WEIGHT_WIDTH-1:0] port_dout [C_NUM_RD_PORTS];

  logic wr_accept, any_active, activate, lk_term;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_word;

  assign any_active = (bank_q[0] == BkActive) || (bank_q[1] == BkActive);
  assign activate   = (bank_q[rd_bank_q] == BkLoaded) && !any_active;
  assign wr_accept  = wht_config_wren && ready_q && !job_accept;
  assign lk_term    = (bank_q[rd_bank_q] == BkActive) && (rd_group_q == full_q[rd_bank_q]);
  assign wr_addr    = {wr_bank_q, wr_group_q, wr_count_q};
`ifdef WHT_TABLE_PARITY_EN
  assign wr_word    = {^wht_config_data, wht_config_data};
`else
  assign wr_word    = wht_config_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q     <= '{BkEmpty, BkEmpty};
      full_q     <= '{'0, '0};
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_group_q <= '0;
      rd_group_q <= '0;
      wr_count_q <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
      swap_q     <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_group_q <= wr_group_d;
      rd_group_q <= rd_group_d;
      wr_count_q <= wr_count_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
      swap_q     <= swap_d;
    end
  end

  always_comb begin
    bank_d     = bank_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_group_d = wr_group_q;
    rd_group_d = rd_group_q;
    wr_count_d = wr_count_q;
    overflow_d = overflow_q;
    swap_d     = 1'b0;
    if (job_accept) begin
      bank_d     = '{BkEmpty, BkEmpty};
      full_d     = '{'0, '0};
      wr_bank_d  = 1'b0;
      rd_bank_d  = 1'b0;
      wr_group_d = '0;
      rd_group_d = '0;
      wr_count_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (kernel_config_valid) full_d[wr_bank_q] = kernel_full_count;
      if (wht_config_wren && !ready_q) overflow_d = 1'b1;
      if (wr_accept) begin
        if (bank_q[wr_bank_q] == BkEmpty) bank_d[wr_bank_q] = BkLoading;
        if (wr_count_q == KMax) begin
          wr_count_d = '0;
          if (wr_group_q == full_q[wr_bank_q]) begin
            bank_d[wr_bank_q] = BkLoaded;
            wr_bank_d         = ~wr_bank_q;
            wr_group_d        = '0;
          end else begin
            wr_group_d = wr_group_q + 1'b1;
          end
        end else begin
          wr_count_d = wr_count_q + 1'b1;
        end
      end
      if (activate) begin
        bank_d[rd_bank_q] = BkActive;
        swap_d            = 1'b1;
        rd_group_d        = '0;
      end
      // Group advance lines up with the last read issued before next_kernel.
      if (nk_q[TOT-1] && (bank_q[rd_bank_q] == BkActive)) begin
        if (rd_group_q < full_q[rd_bank_q]) begin
          rd_group_d = rd_group_q + 1'b1;
        end else begin
          bank_d[rd_bank_q] = BkEmpty;
          rd_bank_d         = ~rd_bank_q;
          rd_group_d        = '0;
        end
      end
    end
    ready_d = (bank_d[wr_bank_d] == BkEmpty) || (bank_d[wr_bank_d] == BkLoading);
  end

  always_comb begin
    wht_config_ready     = ready_q;
    cfg_overflow         = overflow_q;
    bank_swap            = swap_q;
    last_kernel          = lk_q[C_RD_LATENCY-1];
    wht_table_dout_valid = vld_q[TOT-1];
    wht_table_dout       = '0;
    for (int p = 0; p < C_NUM_RD_PORTS; p++) begin
      wht_table_dout[p*C_WEIGHT_WIDTH +: C_WEIGHT_WIDTH] = port_dout[p];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      nk_q   <= '0;
      lk_q   <= '0;
      addr_q <= '0;
    end else if (job_accept) begin
      vld_q <= '0;
      nk_q  <= '0;
      lk_q  <= '0;
    end else begin
      vld_q[0] <= ce_execute && any_active;
      nk_q[0]  <= next_kernel;
      lk_q[0]  <= lk_term;
      for (int i = 1; i < TOT; i++) begin
        vld_q[i] <= vld_q[i-1];
        nk_q[i]  <= nk_q[i-1];
      end
      for (int i = 1; i < C_RD_LATENCY; i++) lk_q[i] <= lk_q[i-1];
      for (int p = 0; p < C_NUM_RD_PORTS; p++) begin
        addr_q[0][p] <= {rd_bank_q, rd_group_q, wht_seq_addr[p*SAW +: SAW]};
      end
      for (int i = 1; i < C_SEQ_ADDR_DELAY; i++) addr_q[i] <= addr_q[i-1];
    end
  end

`ifdef WHT_TABLE_PARITY_EN
  logic par_bad [C_NUM_RD_PORTS];
`endif

  for (genvar p = 0; p < C_NUM_RD_PORTS; p++) begin : g_port
    logic [DW-1:0] mem [2**AW];
    logic [C_RD_LATENCY-1:0][DW-1:0] data_q;

    always_ff @(posedge clk) begin
      if (wr_accept) mem[wr_addr] <= wr_word;
    end

    // Data stages only move with a valid so unwritten RAM never reaches the output.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q <= '0;
      end else begin
        if (vld_q[C_SEQ_ADDR_DELAY-1]) data_q[0] <= mem[addr_q[C_SEQ_ADDR_DELAY-1][p]];
        for (int i = 1; i < C_RD_LATENCY; i++) begin
          if (vld_q[C_SEQ_ADDR_DELAY-1+i]) data_q[i] <= data_q[i-1];
        end
      end
    end

    assign port_dout[p] = data_q[C_RD_LATENCY-1][C_WEIGHT_WIDTH-1:0];
`ifdef WHT_TABLE_PARITY_EN
    assign par_bad[p] = ^data_q[C_RD_LATENCY-1];
`endif
  end

`ifdef WHT_TABLE_PARITY_EN
  logic parity_q, any_bad;

  always_comb begin
    any_bad = 1'b0;
    for (int p = 0; p < C_NUM_RD_PORTS; p++) any_bad = any_bad | par_bad[p];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (job_accept) begin
      parity_q <= 1'b0;
    end else if (vld_q[TOT-1] && any_bad) begin
      parity_q <= 1'b1;
    end
  end

  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_layer_accel_weight_table_pp.sv
// Directed bench for the ping-pong weight table: load, execute, bank swap, overflow, flush, reset.
module tb_cnn_layer_accel_weight_table_pp;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_accept;
  logic        kernel_config_valid;
  logic [5:0]  kernel_full_count;
  logic        wht_config_wren;
  logic [15:0] wht_config_data;
  logic        wht_config_ready;
  logic        cfg_overflow;
  logic        ce_execute;
  logic [7:0]  wht_seq_addr;
  logic        next_kernel;
  logic        last_kernel;
  logic        bank_swap;
  logic [31:0] wht_table_dout;
  logic        wht_table_dout_valid;
  logic        parity_err;

  int checks = 0;
  int errors = 0;
  int n, nv, ns;

  always #5 clk = ~clk;

  cnn_layer_accel_weight_table_pp dut (
    .clk                  (clk),
    .rst                  (rst),
    .job_accept           (job_accept),
    .kernel_config_valid  (kernel_config_valid),
    .kernel_full_count    (kernel_full_count),
    .wht_config_wren      (wht_config_wren),
    .wht_config_data      (wht_config_data),
    .wht_config_ready     (wht_config_ready),
    .cfg_overflow         (cfg_overflow),
    .ce_execute           (ce_execute),
    .wht_seq_addr         (wht_seq_addr),
    .next_kernel          (next_kernel),
    .last_kernel          (last_kernel),
    .bank_swap            (bank_swap),
    .wht_table_dout       (wht_table_dout),
    .wht_table_dout_valid (wht_table_dout_valid),
    .parity_err           (parity_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [5:0] fc, input int cnt, input logic [15:0] base);
    kernel_config_valid = 1'b1;
    kernel_full_count   = fc;
    step();
    kernel_config_valid = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      wht_config_wren = 1'b1;
      wht_config_data = base + 16'(i);
      step();
    end
    wht_config_wren = 1'b0;
  endtask

  // Issues one read and expects valid exactly 6 cycles after ce_execute is sampled.
  task automatic rd_chk(input string tag, input logic [3:0] a1, input logic [3:0] a0,
                        input logic [31:0] exp);
    int k;
    wht_seq_addr = {a1, a0};
    ce_execute   = 1'b1;
    step();
    ce_execute = 1'b0;
    k = 1;
    while (!wht_table_dout_valid && k < 12) begin
      step();
      k++;
    end
    chk({tag, " latency"}, 64'(k), 64'd6);
    chk({tag, " dout"}, 64'(wht_table_dout), 64'(exp));
    step();
    chk({tag, " single valid"}, 64'(wht_table_dout_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    job_accept = 1'b0;
    kernel_config_valid = 1'b0;
    kernel_full_count = '0;
    wht_config_wren = 1'b0;
    wht_config_data = '0;
    ce_execute = 1'b0;
    wht_seq_addr = '0;
    next_kernel = 1'b0;
    step();
    step();
    chk("rst ready", 64'(wht_config_ready), 64'd0);
    chk("rst overflow", 64'(cfg_overflow), 64'd0);
    chk("rst swap", 64'(bank_swap), 64'd0);
    chk("rst last", 64'(last_kernel), 64'd0);
    chk("rst valid", 64'(wht_table_dout_valid), 64'd0);
    chk("rst dout", 64'(wht_table_dout), 64'd0);
    chk("rst parity", 64'(parity_err), 64'd0);
    rst = 1'b0;
    step();
    chk("idle ready", 64'(wht_config_ready), 64'd1);

    // Bank 0: two groups of nine words.
    load(6'd1, 18, 16'h0100);
    chk("load0 ready", 64'(wht_config_ready), 64'd1);
    chk("load0 swap early", 64'(bank_swap), 64'd0);
    step();
    chk("load0 swap", 64'(bank_swap), 64'd1);
    step();
    chk("load0 swap pulse", 64'(bank_swap), 64'd0);
    rd_chk("exec g0", 4'd5, 4'd3, 32'h0105_0103);
    chk("g0 last", 64'(last_kernel), 64'd0);

    // Bank 1 fills while bank 0 stays active.
    load(6'd1, 18, 16'h0200);
    chk("load1 ready", 64'(wht_config_ready), 64'd0);
    chk("load1 no swap", 64'(bank_swap), 64'd0);
    next_kernel = 1'b1;
    step();
    next_kernel = 1'b0;
    n = 1;
    while (!last_kernel && n < 20) begin
      step();
      n++;
    end
    chk("last latency", 64'(n), 64'd10);
    rd_chk("exec g1", 4'd2, 4'd7, 32'h010B_0110);
    chk("g1 last", 64'(last_kernel), 64'd1);

    next_kernel = 1'b1;
    step();
    next_kernel = 1'b0;
    n = 1;
    while (!bank_swap && n < 20) begin
      step();
      n++;
    end
    chk("release swap latency", 64'(n), 64'd8);
    chk("release ready", 64'(wht_config_ready), 64'd1);
    step();
    step();
    chk("bank1 last", 64'(last_kernel), 64'd0);
    rd_chk("exec bank1", 4'd0, 4'd8, 32'h0200_0208);

    // Both banks busy: the extra word must be dropped and flagged.
    load(6'd0, 9, 16'h0300);
    chk("full ready", 64'(wht_config_ready), 64'd0);
    chk("pre overflow", 64'(cfg_overflow), 64'd0);
    wht_config_wren = 1'b1;
    wht_config_data = 16'hDEAD;
    step();
    wht_config_wren = 1'b0;
    chk("overflow set", 64'(cfg_overflow), 64'd1);
    step();
    step();
    chk("overflow sticky", 64'(cfg_overflow), 64'd1);
    rd_chk("ovf ram intact", 4'd0, 4'd0, 32'h0200_0200);

    // Flush with a read and a group advance still in flight.
    wht_seq_addr = '0;
    ce_execute   = 1'b1;
    next_kernel  = 1'b1;
    step();
    ce_execute  = 1'b0;
    next_kernel = 1'b0;
    job_accept  = 1'b1;
    step();
    job_accept = 1'b0;
    chk("flush ready", 64'(wht_config_ready), 64'd1);
    chk("flush last", 64'(last_kernel), 64'd0);
    chk("flush overflow", 64'(cfg_overflow), 64'd0);
    ce_execute = 1'b1;
    step();
    ce_execute = 1'b0;
    nv = 0;
    ns = 0;
    for (int i = 0; i < 12; i++) begin
      if (wht_table_dout_valid) nv++;
      if (bank_swap) ns++;
      step();
    end
    chk("flush valids", 64'(nv), 64'd0);
    chk("flush swaps", 64'(ns), 64'd0);
    chk("flush last hold", 64'(last_kernel), 64'd0);

    // Single-group reload after the flush.
    load(6'd0, 9, 16'h0400);
    n = 0;
    while (!bank_swap && n < 5) begin
      step();
      n++;
    end
    chk("reload swap", 64'(n), 64'd1);
    rd_chk("reload", 4'd1, 4'd4, 32'h0401_0404);
    chk("reload last", 64'(last_kernel), 64'd1);

    // Asynchronous reset with a read in flight.
    wht_seq_addr = 8'h21;
    ce_execute   = 1'b1;
    step();
    ce_execute = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("async valid", 64'(wht_table_dout_valid), 64'd0);
    chk("async ready", 64'(wht_config_ready), 64'd0);
    chk("async last", 64'(last_kernel), 64'd0);
    chk("async dout", 64'(wht_table_dout), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (wht_table_dout_valid) nv++;
    end
    chk("post rst valids", 64'(nv), 64'd0);
    chk("post rst ready", 64'(wht_config_ready), 64'd1);
    chk("parity clean", 64'(parity_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
